pipe_ctrl_gen: RTL and testbench

//  Parametrised successor of the pipeline stall/flush controller. It sits between the per-stage

---
 rtl/pipe_ctrl_gen.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen
//   Pipeline stall/flush controller. It sits between the per-stage stall
//   requesters, the CP0/exception unit and pc_reg. It produces the per-stage
//   stall vector, a flush window of FLUSH_CYCLES cycles with the exception
//   target PC held alongside it, and a sticky consecutive-stall watchdog flag.
//
// Parameters
//   NSTAGE       number of pipeline stages (>=3)
//   FLUSH_CYCLES cycles flush/new_pc stay asserted per exception (>=1)
//   STALL_TMO    consecutive stalled cycles that trip the watchdog (>=2)
//   USE_EBASE    1: BEV=0 vector base comes from EBase; 0: fixed 0x80000000
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   stallreq     per-stage stall requests (bit0 = pc ... bitN-1 = wb)
//   stall_all    global freeze, stalls every stage
//   exc_code     0 none, 1 reset, 2 tlb refill, 3 interrupt, 4 eret, 5-7 general
//   cp0_epc_i    EPC, used as the eret target
//   ebase_i      EBase, supplies the BEV=0 vector base
//   status_i     CP0 Status ([22]=BEV, [1]=EXL)
//   cause_i      CP0 Cause ([23]=IV)
//   tmo_clr      clears the sticky watchdog flag
//   stall        stall[k]=1 holds stage k
//   flush        pipeline flush
//   new_pc       exception/eret target, valid while flush=1, else 0
//   stall_tmo    sticky watchdog flag
module pipe_ctrl_gen #(
  parameter int NSTAGE       = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_TMO    = 255,
  parameter int USE_EBASE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              stall_all,
  input  logic [2:0]        exc_code,
  input  logic [31:0]       cp0_epc_i,
  input  logic [31:0]       ebase_i,
  input  logic [31:0]       status_i,
  input  logic [31:0]       cause_i,
  input  logic              tmo_clr,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_tmo
);

  // Counter holds FLUSH_CYCLES-1, i.e. the cycles remaining after cycle 0.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TCW = $clog2(STALL_TMO + 1);
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_MAX    = TCW'(STALL_TMO);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(STALL_TMO - 1);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0]     held_pc_q, held_pc_d;
  logic [TCW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic            stall_tmo_q, stall_tmo_d;

  logic            accept;
  logic [31:0]     vector;
  logic [31:0]     base;
  logic [NSTAGE-1:0] req_mask;
  logic            bev, exl, iv;

  // Only a few CSR bits matter; the rest are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{status_i[31:23], status_i[21:2], status_i[0],
                         cause_i[31:24], cause_i[22:0], ebase_i[11:0]};

  assign bev = status_i[22];
  assign exl = status_i[1];
  assign iv  = cause_i[23];

  // Exception acceptance and vector selection. A reset request may preempt
  // an open flush window; any other code arriving in FLUSH is dropped.
  always_comb begin
    base   = (USE_EBASE != 0) ? {ebase_i[31:12], 12'h000} : 32'h8000_0000;
    accept = !rst && (exc_code != 3'd0) &&
             ((state_q == ST_IDLE) || (exc_code == 3'd1));
    case (exc_code)
      3'd0:    vector = 32'h0000_0000;
      3'd1:    vector = 32'hBFC0_0000;
      3'd2:    vector = bev ? (exl ? 32'hBFC0_0380 : 32'hBFC0_0200)
                            : (exl ? base + 32'h180 : base);
      3'd3:    vector = bev ? (iv ? 32'hBFC0_0400 : 32'hBFC0_0380)
                            : (iv ? base + 32'h200 : base + 32'h180);
      3'd4:    vector = cp0_epc_i;
      default: vector = bev ? 32'hBFC0_0380 : base + 32'h180;
    endcase
  end

  // Thermometer of the highest requesting stage: everything upstream of it
  // must hold as well.
  always_comb begin
    req_mask = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (k == NSTAGE - 1) req_mask[k] = stallreq[k];
      else                 req_mask[k] = stallreq[k] | req_mask[k+1];
    end
  end

  // State register; reset is applied through the _d logic.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    flush_cnt_q <= flush_cnt_d;
    held_pc_q   <= held_pc_d;
    tmo_cnt_q   <= tmo_cnt_d;
    stall_tmo_q <= stall_tmo_d;
  end

  // Next-state logic for the flush window. The vector is captured only at
  // acceptance so CSR changes during the window cannot disturb new_pc.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    held_pc_d   = held_pc_q;
    if (rst) begin
      state_d     = ST_IDLE;
      flush_cnt_d = '0;
      held_pc_d   = '0;
    end else if (accept) begin
      held_pc_d   = vector;
      flush_cnt_d = FLUSH_INIT;
      state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - FCW'(1);
      if (flush_cnt_q <= FCW'(1)) state_d = ST_IDLE;
    end
  end

  // Outputs. Flush beats any stall request, and reset silences everything.
  always_comb begin
    flush     = 1'b0;
    new_pc    = '0;
    stall     = '0;
    stall_tmo = 1'b0;
    if (!rst) begin
      stall_tmo = stall_tmo_q;
      if (accept) begin
        flush  = 1'b1;
        new_pc = vector;
      end else if (state_q == ST_FLUSH) begin
        flush  = 1'b1;
        new_pc = held_pc_q;
      end else if (stall_all) begin
        stall = '1;
      end else begin
        stall = req_mask;
      end
    end
  end

  // Watchdog: counts consecutive stalled cycles, saturating. The flag is set
  // on the edge where the count reaches STALL_TMO; a clear request wins.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    stall_tmo_d = stall_tmo_q;
    if (rst) begin
      tmo_cnt_d   = '0;
      stall_tmo_d = 1'b0;
    end else begin
      if (stall == '0)              tmo_cnt_d = '0;
      else if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TCW'(1);
      if (tmo_clr)
        stall_tmo_d = 1'b0;
      else if ((stall != '0) && (tmo_cnt_q == TMO_LAST))
        stall_tmo_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Testbench for pipe_ctrl_gen. Two instances share the inputs:
//   dut_a: FLUSH_CYCLES=3, STALL_TMO=4, USE_EBASE=1
//   dut_b: FLUSH_CYCLES=4, STALL_TMO=4, USE_EBASE=0
// Each cycle's stimulus is pushed together with the expected outputs onto a
// scoreboard queue; the monitor pops and compares mid-cycle.
module tb_pipe_ctrl_gen;

  localparam logic [31:0] BEV   = 32'h0040_0000;
  localparam logic [31:0] IV    = 32'h0080_0000;
  localparam logic [31:0] EPC   = 32'h8000_0ABC;
  localparam logic [31:0] EBASE = 32'h8000_1000;

  typedef struct packed {
    logic       rst;
    logic [5:0] stallreq;
    logic       stall_all;
    logic [2:0] exc_code;
    logic [31:0] status;
    logic [31:0] cause;
    logic       tmo_clr;
  } stim_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_tmo;
  } out_t;

  typedef struct packed {
    out_t ea;
    out_t eb;
    logic ca;
    logic cb;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stallreq = '0;
  logic        stall_all = 1'b0;
  logic [2:0]  exc_code = '0;
  logic [31:0] cp0_epc_i = EPC;
  logic [31:0] ebase_i = EBASE;
  logic [31:0] status_i = '0;
  logic [31:0] cause_i = '0;
  logic        tmo_clr = 1'b0;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [31:0] new_pc_a, new_pc_b;
  logic        stall_tmo_a, stall_tmo_b;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;
  sb_t sb[$];
  out_t z = '0;

  always #5 clk = ~clk;

  pipe_ctrl_gen #(.NSTAGE(6), .FLUSH_CYCLES(3), .STALL_TMO(4), .USE_EBASE(1)) dut_a (
    .clk(clk), .rst(rst), .stallreq(stallreq), .stall_all(stall_all),
    .exc_code(exc_code), .cp0_epc_i(cp0_epc_i), .ebase_i(ebase_i),
    .status_i(status_i), .cause_i(cause_i), .tmo_clr(tmo_clr),
    .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a), .stall_tmo(stall_tmo_a)
  );

  pipe_ctrl_gen #(.NSTAGE(6), .FLUSH_CYCLES(4), .STALL_TMO(4), .USE_EBASE(0)) dut_b (
    .clk(clk), .rst(rst), .stallreq(stallreq), .stall_all(stall_all),
    .exc_code(exc_code), .cp0_epc_i(cp0_epc_i), .ebase_i(ebase_i),
    .status_i(status_i), .cause_i(cause_i), .tmo_clr(tmo_clr),
    .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b), .stall_tmo(stall_tmo_b)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic stim_t mkStim(input logic r, input logic [5:0] req,
                                   input logic all, input logic [2:0] exc,
                                   input logic [31:0] status, input logic [31:0] cause,
                                   input logic clr);
    stim_t s;
    s.rst = r; s.stallreq = req; s.stall_all = all; s.exc_code = exc;
    s.status = status; s.cause = cause; s.tmo_clr = clr;
    return s;
  endfunction

  function automatic out_t mkOut(input logic [5:0] s, input logic f,
                                 input logic [31:0] pc, input logic t);
    out_t o;
    o.stall = s; o.flush = f; o.new_pc = pc; o.stall_tmo = t;
    return o;
  endfunction

  // Drives one cycle of stimulus just after the rising edge and records
  // what each checked instance must show during that cycle.
  task automatic applyStimulus(input stim_t s, input out_t ea, input out_t eb,
                               input logic ca, input logic cb);
    sb_t e;
    @(posedge clk);
    #1;
    rst       = s.rst;
    stallreq  = s.stallreq;
    stall_all = s.stall_all;
    exc_code  = s.exc_code;
    status_i  = s.status;
    cause_i   = s.cause;
    tmo_clr   = s.tmo_clr;
    e.ea = ea; e.eb = eb; e.ca = ca; e.cb = cb;
    sb.push_back(e);
  endtask

  task automatic stepA(input stim_t s, input out_t ea);
    applyStimulus(s, ea, '0, 1'b1, 1'b0);
  endtask

  task automatic stepAB(input stim_t s, input out_t ea, input out_t eb);
    applyStimulus(s, ea, eb, 1'b1, 1'b1);
  endtask

  // Monitor: compares mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      cycle++;
      if (e.ca) begin
        checkOutput($sformatf("c%0d a.stall", cycle), 32'(stall_a), 32'(e.ea.stall));
        checkOutput($sformatf("c%0d a.flush", cycle), 32'(flush_a), 32'(e.ea.flush));
        checkOutput($sformatf("c%0d a.new_pc", cycle), new_pc_a, e.ea.new_pc);
        checkOutput($sformatf("c%0d a.tmo", cycle), 32'(stall_tmo_a), 32'(e.ea.stall_tmo));
      end
      if (e.cb) begin
        checkOutput($sformatf("c%0d b.stall", cycle), 32'(stall_b), 32'(e.eb.stall));
        checkOutput($sformatf("c%0d b.flush", cycle), 32'(flush_b), 32'(e.eb.flush));
        checkOutput($sformatf("c%0d b.new_pc", cycle), new_pc_b, e.eb.new_pc);
        checkOutput($sformatf("c%0d b.tmo", cycle), 32'(stall_tmo_b), 32'(e.eb.stall_tmo));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state of both instances
    repeat (2) stepAB(mkStim(1, 6'b0, 0, 0, 0, 0, 0), z, z);

    // Stall encoding
    stepA(mkStim(0, 6'b010000, 0, 0, 0, 0, 0), mkOut(6'b011111, 0, 0, 0));
    stepA(mkStim(0, 6'b010100, 0, 0, 0, 0, 0), mkOut(6'b011111, 0, 0, 0));
    stepA(mkStim(0, 6'b000000, 1, 0, 0, 0, 0), mkOut(6'b111111, 0, 0, 0));
    // Three stalled cycles then idle: watchdog must not trip
    repeat (2) stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // Exception beats a stall request in the same cycle; EBase-relative vector
    stepA(mkStim(0, 6'b001000, 0, 5, 0, 0, 0), mkOut(6'b0, 1, 32'h8000_1180, 0));
    repeat (2) stepA(mkStim(0, 6'b001000, 0, 0, 0, 0, 0), mkOut(6'b0, 1, 32'h8000_1180, 0));
    stepA(mkStim(0, 6'b001000, 0, 0, 0, 0, 0), mkOut(6'b001111, 0, 0, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // Interrupt, BEV=1 IV=1: held vector survives a Status change
    stepA(mkStim(0, 6'b0, 0, 3, BEV, IV, 0), mkOut(6'b0, 1, 32'hBFC0_0400, 0));
    repeat (2) stepA(mkStim(0, 6'b0, 0, 0, 0, IV, 0), mkOut(6'b0, 1, 32'hBFC0_0400, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // A general exception inside the window is dropped
    stepA(mkStim(0, 6'b0, 0, 3, BEV, IV, 0), mkOut(6'b0, 1, 32'hBFC0_0400, 0));
    stepA(mkStim(0, 6'b0, 0, 5, 0, 0, 0), mkOut(6'b0, 1, 32'hBFC0_0400, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), mkOut(6'b0, 1, 32'hBFC0_0400, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // A reset request inside the window restarts it with the reset vector
    stepA(mkStim(0, 6'b0, 0, 3, BEV, IV, 0), mkOut(6'b0, 1, 32'hBFC0_0400, 0));
    stepA(mkStim(0, 6'b0, 0, 1, 0, 0, 0), mkOut(6'b0, 1, 32'hBFC0_0000, 0));
    repeat (2) stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), mkOut(6'b0, 1, 32'hBFC0_0000, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // eret goes to EPC
    stepA(mkStim(0, 6'b0, 0, 4, 0, 0, 0), mkOut(6'b0, 1, EPC, 0));
    repeat (2) stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), mkOut(6'b0, 1, EPC, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // Watchdog: four stalled cycles trip it, visible on the fifth
    repeat (4) stepA(mkStim(0, 6'b000001, 0, 0, 0, 0, 0), mkOut(6'b000001, 0, 0, 0));
    repeat (2) stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), mkOut(6'b0, 0, 0, 1));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 1), mkOut(6'b0, 0, 0, 1));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);

    // Clear wins over a simultaneous set
    repeat (3) stepA(mkStim(0, 6'b000001, 0, 0, 0, 0, 0), mkOut(6'b000001, 0, 0, 0));
    stepA(mkStim(0, 6'b000001, 0, 0, 0, 0, 1), mkOut(6'b000001, 0, 0, 0));
    stepA(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z);
    repeat (3) stepA(mkStim(0, 6'b000001, 0, 0, 0, 0, 0), mkOut(6'b000001, 0, 0, 0));

    // Both instances: reset, then tlb refill (BEV=0, EXL=0)
    stepAB(mkStim(1, 6'b000001, 0, 0, 0, 0, 0), z, z);
    stepAB(mkStim(0, 6'b0, 0, 2, 0, 0, 0),
           mkOut(6'b0, 1, 32'h8000_1000, 0), mkOut(6'b0, 1, 32'h8000_0000, 0));
    // Reset in cycle 1 of the window silences outputs at once
    stepAB(mkStim(1, 6'b000001, 0, 0, 0, 0, 0), z, z);
    // Window aborted; watchdog restarts from zero
    repeat (4) stepAB(mkStim(0, 6'b000001, 0, 0, 0, 0, 0),
                      mkOut(6'b000001, 0, 0, 0), mkOut(6'b000001, 0, 0, 0));
    stepAB(mkStim(0, 6'b0, 0, 0, 0, 0, 0), mkOut(6'b0, 0, 0, 1), mkOut(6'b0, 0, 0, 1));

    // Interrupt BEV=0 IV=0: three-cycle window vs four-cycle window
    stepAB(mkStim(0, 6'b0, 0, 3, 0, 0, 0),
           mkOut(6'b0, 1, 32'h8000_1180, 1), mkOut(6'b0, 1, 32'h8000_0180, 1));
    repeat (2) stepAB(mkStim(0, 6'b0, 0, 0, 0, 0, 0),
                      mkOut(6'b0, 1, 32'h8000_1180, 1), mkOut(6'b0, 1, 32'h8000_0180, 1));
    stepAB(mkStim(0, 6'b0, 0, 0, 0, 0, 0),
           mkOut(6'b0, 0, 0, 1), mkOut(6'b0, 1, 32'h8000_0180, 1));
    stepAB(mkStim(0, 6'b0, 0, 0, 0, 0, 0), mkOut(6'b0, 0, 0, 1), mkOut(6'b0, 0, 0, 1));
    stepAB(mkStim(0, 6'b0, 0, 0, 0, 0, 1), mkOut(6'b0, 0, 0, 1), mkOut(6'b0, 0, 0, 1));
    stepAB(mkStim(0, 6'b0, 0, 0, 0, 0, 0), z, z);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
